uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver with the same register-mapped host interface (en/addr/re/we/wdata) as the UART transmitter.
- Synchronises the asynchronous rx line and detects the start bit.
- Samples each bit at mid-bit using a programmable clocks-per-bit divisor.
- Presents received bytes and status flags through a 4-register map.

Parameters:
- DIV_RST, 8'd130, divisor reset value in clocks per bit.
- DIV_MIN, 4, smallest divisor used; programmed values below it are clamped to it.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  receiver enable. When 0, the FSM is held in IDLE. Register access still works.
- addr  in  2  register address: 00 RXDATA, 01 STATUS, 10 DIVISOR, 11 CTRL.
- re  in  1  read strobe, one cycle.
- we  in  1  write strobe, one cycle. we wins if re and we are both high.
- wdata  in  8  write data.
- rdata  out  8  read data, registered.
- rx  in  1  serial input, asynchronous, idle high.
- rx_irq  out  1  equals rx_valid AND ctrl.irq_en.

Behaviour:
- Reset values:
  - rdata=0, rx_irq=0, rx_data=0, divisor=DIV_RST.
  - ctrl=0, status flags=0, FSM=IDLE, bit/clock counters=0.
  - Both synchroniser flops reset to 1.
- rx passes through a 2-flop synchroniser, giving rx_s. This adds 2 cycles of latency.
- Register map:
  - 00 RXDATA: read returns rx_data and clears rx_valid at the same edge. Writes are ignored.
  - 01 STATUS:
    - bit0 rx_valid, bit1 overrun, bit2 frame_err, bit3 busy (FSM != IDLE), bits7:4 = 0.
    - Write 1 to bit1 or bit2 clears that flag (W1C).
  - 10 DIVISOR: read/write, 8 bits.
  - 11 CTRL: bit0 irq_en. Other bits read as 0.
- Read timing: rdata is updated on the edge where re=1 and shows the pre-edge register value. It is valid in the next cycle and holds until the next read.
- Effective divisor D = max(divisor, DIV_MIN). D is latched into div_q when the start edge is detected. A divisor write mid-frame affects the next frame only.
- FSM:
  - IDLE: when en=1 and rx_s goes 1->0 (tracked by a previous-sample register), clear cnt, latch D, go START.
  - START:
    - cnt counts up. At cnt == (div_q>>1)-1, sample rx_s.
    - If rx_s=1: false start, go IDLE.
    - Otherwise clear cnt, bitn=0, go DATA.
  - DATA:
    - At cnt == div_q-1, shift rx_s into shift[7] (LSB first, shift right) and clear cnt.
    - After bitn==7, go STOP; otherwise bitn++.
  - STOP: at cnt == div_q-1, sample rx_s.
    - rx_s=1, rx_valid=0: rx_data <= shift, rx_valid <= 1.
    - rx_s=1, rx_valid=1: keep the old rx_data, drop the new byte, overrun <= 1.
    - rx_s=0: frame_err <= 1, byte dropped, rx_valid unchanged.
    - In all cases go IDLE. A new start needs a fresh 1->0 edge.
- Simultaneous events:
  - Byte completes in the same cycle as an RXDATA read: rdata gets the old byte. The new byte loads and rx_valid ends at 1 (set wins over clear). No overrun.
  - W1C of a flag in the same cycle it is set: set wins.
- en deasserted mid-frame: FSM returns to IDLE next edge. The partial byte is discarded and no flags change.
- rst mid-frame: everything returns to reset values next edge.
- Latency: rx_valid rises 2 + 9.5·D cycles (±1) after the rx falling edge.

Decomposition:
- Shared package uart_pkg holds:
  - register address constants ADDR_DATA/STATUS/DIV/CTRL;
  - STATUS bit indices;
  - FSM state enum (IDLE, START, DATA, STOP);
  - DIV_MIN.
- One natural sub-module: uart_sync2, the 2-flop synchroniser with reset-to-1.
- The baud counter and FSM stay in uart_rx.

Test Plan:
- Reset then read STATUS, DIVISOR, CTRL -> rdata = 0x00, 0x82, 0x00; rx_irq=0.
- Write DIVISOR=16, en=1, drive 0xA5 8N1 at 16 clk/bit -> STATUS=0x01. Read RXDATA -> 0xA5. STATUS then reads 0x00.
- Send 0x3C then 0xC3 without reading -> STATUS=0x03 and RXDATA=0x3C. W1C 0x02 -> STATUS=0x01.
- 0x55 frame with stop bit driven 0 -> STATUS bit2=1, rx_valid=0. W1C 0x04 clears it.
- 4-clock low glitch on rx with D=16 -> FSM returns to IDLE, busy drops, no flags set.
- CTRL=1: rx_irq rises with rx_valid after byte 0x81. Drop en mid-frame -> busy=0 next cycle, no byte delivered. Divisor=2 behaves as 4.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: register map, status bit positions, receiver states and divisor floor shared by the UART blocks.
package uart_pkg;
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;
  localparam int ST_VALID   = 0;
  localparam int ST_OVERRUN = 1;
  localparam int ST_FRAME   = 2;
  localparam int ST_BUSY    = 3;
  localparam int DIV_MIN    = 4;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an idle-high asynchronous input; both stages reset to 1.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], d};
  always_ff @(posedge clk) sync_q <= rst ? 2'b11 : sync_d;
  assign q = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling, programmable divisor and a 4-register host interface.
module uart_rx import uart_pkg::*; #(
  parameter logic [7:0] DIV_RST = 8'd130,
  parameter int         DIV_MIN = uart_pkg::DIV_MIN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] addr,
  input  logic       re,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       rx,
  output logic       rx_irq
);
  rx_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d, div_q, div_d, shift_q, shift_d, rx_data_q, rx_data_d;
  logic [7:0] div_reg_q, div_reg_d, rdata_q, rdata_d, d_eff, rd_mux;
  logic [2:0] bitn_q, bitn_d;
  logic       rx_valid_q, rx_valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic       irq_en_q, irq_en_d, rx_prev_q, rx_s;
  logic       rd, wr, done_ok, done_bad, valid_kept, w1c_st;
  uart_sync2 u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));
  assign rd     = re & ~we;
  assign wr     = we;
  assign w1c_st = wr && addr == ADDR_STATUS;
  assign d_eff  = (div_reg_q < 8'(DIV_MIN)) ? 8'(DIV_MIN) : div_reg_q;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 8'd1;
    bitn_d   = bitn_q;
    shift_d  = shift_q;
    div_d    = div_q;
    done_ok  = 1'b0;
    done_bad = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s) begin
          state_d = START;
          div_d   = d_eff;
        end
      end
      START: if (cnt_q == (div_q >> 1) - 8'd1) begin
        cnt_d   = '0;
        bitn_d  = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == div_q - 8'd1) begin
        cnt_d   = '0;
        shift_d = {rx_s, shift_q[7:1]};
        bitn_d  = bitn_q + 3'd1;
        state_d = (bitn_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt_q == div_q - 8'd1) begin
        cnt_d    = '0;
        state_d  = IDLE;
        done_ok  = rx_s;
        done_bad = ~rx_s;
      end
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      done_ok  = 1'b0;
      done_bad = 1'b0;
    end
  end
  // A same-edge RXDATA read frees the holding register, so a completing byte loads instead of overrunning.
  always_comb begin
    valid_kept  = rx_valid_q & ~(rd && addr == ADDR_DATA);
    rx_valid_d  = valid_kept | done_ok;
    rx_data_d   = (done_ok && !valid_kept) ? shift_q : rx_data_q;
    overrun_d   = (overrun_q & ~(w1c_st & wdata[ST_OVERRUN])) | (done_ok & valid_kept);
    frame_err_d = (frame_err_q & ~(w1c_st & wdata[ST_FRAME])) | done_bad;
    div_reg_d   = (wr && addr == ADDR_DIV) ? wdata : div_reg_q;
    irq_en_d    = (wr && addr == ADDR_CTRL) ? wdata[0] : irq_en_q;
    rd_mux      = addr == ADDR_DATA   ? rx_data_q :
                  addr == ADDR_STATUS ? {4'b0, state_q != IDLE, frame_err_q, overrun_q, rx_valid_q} :
                  addr == ADDR_DIV    ? div_reg_q : {7'b0, irq_en_q};
    rdata_d     = rd ? rd_mux : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitn_q      <= '0;
      shift_q     <= '0;
      div_q       <= DIV_RST;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      div_reg_q   <= DIV_RST;
      irq_en_q    <= 1'b0;
      rdata_q     <= '0;
      rx_prev_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitn_q      <= bitn_d;
      shift_q     <= shift_d;
      div_q       <= div_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      div_reg_q   <= div_reg_d;
      irq_en_q    <= irq_en_d;
      rdata_q     <= rdata_d;
      rx_prev_q   <= rx_s;
    end
  end
  assign rdata  = rdata_q;
  assign rx_irq = rx_valid_q & irq_en_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus against a flag-level receiver model; register reads are scoreboarded.
module tb_uart_rx;
  logic       clk = 0, rst = 1, en = 0, re = 0, we = 0, rx = 1;
  logic [1:0] addr = 0;
  logic [7:0] wdata = 0, rdata;
  logic       rx_irq;
  int         checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];
  logic       rd_seen = 0;
  logic       m_valid = 0, m_ov = 0, m_fe = 0;
  logic [7:0] m_data = 0;
  int         lat;

  uart_rx dut (.clk(clk), .rst(rst), .en(en), .addr(addr), .re(re), .we(we),
               .wdata(wdata), .rdata(rdata), .rx(rx), .rx_irq(rx_irq));

  always #5 clk = ~clk;

  always @(posedge clk) rd_seen <= re & ~we;
  always @(negedge clk) if (rd_seen) begin
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_read got %02h expected none", rdata);
    end else begin
      automatic logic [7:0] e = exp_q.pop_front();
      automatic string t = tag_q.pop_front();
      if (rdata !== e) begin
        errors++;
        $display("FAIL %s got %02h expected %02h", t, rdata, e);
      end
    end
  end

  task automatic chk(input string t, input logic [7:0] act, input logic [7:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s got %02h expected %02h", t, act, e);
    end
  endtask

  function automatic logic [7:0] mstat();
    return {5'b0, m_fe, m_ov, m_valid};
  endfunction

  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string t);
    addr = a; re = 1;
    exp_q.push_back(e); tag_q.push_back(t);
    @(negedge clk);
    re = 0;
  endtask

  task automatic rd_data(input string t);
    rd(2'd0, m_data, t);
    m_valid = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr = a; wdata = d; we = 1;
    @(negedge clk);
    we = 0;
  endtask

  task automatic frame(input logic [7:0] b, input int d, input bit stop_ok);
    rx = 0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (d) @(negedge clk);
    end
    rx = stop_ok;
    repeat (d) @(negedge clk);
    rx = 1;
    repeat (d + 4) @(negedge clk);
    if (!stop_ok) m_fe = 1;
    else if (m_valid) m_ov = 1;
    else begin m_data = b; m_valid = 1; end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    rd(2'd1, 8'h00, "reset_status");
    rd(2'd2, 8'h82, "reset_divisor");
    rd(2'd3, 8'h00, "reset_ctrl");
    rd(2'd0, 8'h00, "reset_rxdata");
    chk("reset_irq", {7'b0, rx_irq}, 8'h00);

    wr(2'd2, 8'd16); en = 1;
    frame(8'hA5, 16, 1);
    rd(2'd1, mstat(), "status_after_a5");
    rd_data("rxdata_a5");
    rd(2'd1, mstat(), "status_after_read");

    frame(8'h3C, 16, 1);
    frame(8'hC3, 16, 1);
    rd(2'd1, mstat(), "status_overrun");
    wr(2'd1, 8'h02); m_ov = 0;
    rd(2'd1, mstat(), "status_ovr_cleared");
    rd_data("rxdata_3c_kept");

    frame(8'h55, 16, 0);
    rd(2'd1, mstat(), "status_frame_err");
    wr(2'd1, 8'h04); m_fe = 0;
    rd(2'd1, mstat(), "status_fe_cleared");

    rx = 0;
    repeat (4) @(negedge clk);
    rx = 1;
    repeat (2) @(negedge clk);
    rd(2'd1, 8'h08, "glitch_busy");
    repeat (20) @(negedge clk);
    rd(2'd1, 8'h00, "glitch_idle");

    wr(2'd3, 8'h01);
    rd(2'd3, 8'h01, "ctrl_readback");
    fork
      frame(8'h81, 16, 1);
      begin
        lat = 0;
        while (!rx_irq && lat < 400) begin @(negedge clk); lat++; end
      end
    join
    checks++;
    if (lat < 150 || lat > 160) begin
      errors++;
      $display("FAIL irq_latency got %0d expected 150..160", lat);
    end
    chk("irq_high", {7'b0, rx_irq}, 8'h01);
    rd_data("rxdata_81");
    chk("irq_low_after_read", {7'b0, rx_irq}, 8'h00);

    rx = 0;
    repeat (16) @(negedge clk);
    rx = 1;
    repeat (16) @(negedge clk);
    rx = 0;
    repeat (16) @(negedge clk);
    rd(2'd1, 8'h08, "busy_before_en_drop");
    en = 0;
    @(negedge clk);
    rd(2'd1, 8'h00, "idle_after_en_drop");
    rx = 1;
    repeat (200) @(negedge clk);
    en = 1;
    rd(2'd1, 8'h00, "no_byte_after_abort");

    wr(2'd2, 8'd2);
    rd(2'd2, 8'h02, "divisor_readback_2");
    frame(8'h6E, 4, 1);
    rd(2'd1, mstat(), "status_div2");
    rd_data("rxdata_div2");
    wr(2'd3, 8'h00);

    for (int i = 0; i < 12; i++) begin
      automatic int dv = $urandom_range(0, 20);
      automatic logic [7:0] b = 8'($urandom);
      automatic bit good = $urandom_range(0, 4) != 0;
      wr(2'd2, 8'(dv));
      frame(b, dv < 4 ? 4 : dv, good);
      if ($urandom_range(0, 1) == 1) rd(2'd1, mstat(), "rand_status");
      if ($urandom_range(0, 2) != 0) rd_data("rand_rxdata");
      if ($urandom_range(0, 3) == 0) begin
        wr(2'd1, 8'h06); m_ov = 0; m_fe = 0;
      end
    end
    rd(2'd1, mstat(), "final_status");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL pending_reads got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
